dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported, byte-enabled data memory between the instruction-fetch requester (I) and the MEM-stage load/store requester (D). Each cycle it grants at most one request, drives the memory's word address, write data and byte write enables, and returns registered read data to the granted port one cycle later. It sits between the pipeline's memory-access logic and the data memory array, which performs combinational reads and writes on the rising clock edge.

## Interface
- STARVE_LIMIT, 4: consecutive cycles port I may wait before it is force-granted (fixed-priority mode only); legal range 1..255.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- i_valid  in  1  port I request present.
- i_addr  in  32  port I byte address; bits [1:0] ignored.
- i_be  in  4  port I byte write enables; 4'b0000 means read.
- i_wdata  in  32  port I write data.
- i_ready  out  1  port I request accepted this cycle (combinational).
- i_rsp_valid  out  1  port I response valid.
- i_rdata  out  32  port I read data.
- d_valid, d_addr, d_be, d_wdata, d_ready, d_rsp_valid, d_rdata: same as the port I signals, for port D.
- mem_addr  out  32  byte address to memory.
- mem_we  out  4  byte write enables to memory.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- Grant is computed combinationally from the valid inputs and registered state. A request is accepted when valid && ready is high at a rising edge.
- Only one of i_ready and d_ready may be high in a cycle. A ready is never asserted without its matching valid.
- Memory-side outputs while granted:
  - mem_addr = {addr[31:2], 2'b00} of the granted port.
  - mem_we = be of the granted port.
  - mem_wdata = wdata of the granted port.
- Memory-side outputs while idle: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Arbitration state: last_grant register (0 = I, 1 = D) and an 8-bit starve counter.
- Fixed-priority mode (macro absent):
  - D wins over I.
  - The counter increments each cycle that i_valid is high and I is not granted, saturating at 255.
  - The counter clears when I is granted or i_valid is low.
  - When counter >= STARVE_LIMIT and i_valid is high, I wins over D.
- Response:
  - On acceptance, the granted port's rsp_valid is set for exactly the next cycle.
  - For reads, rdata latches mem_rdata.
  - For writes, rdata latches 32'h0.
  - The other port's rsp_valid is 0 in that cycle.
- Back-to-back: a new request can be accepted every cycle. A response and a new grant may coincide.
- Write then read of the same word in consecutive cycles: the read returns the newly written bytes, because the memory write lands at the accepting edge. Bytes with be = 0 keep their old value.
- Reset (also mid-operation):
  - Any pending response is dropped.
  - i_rsp_valid = d_rsp_valid = 0, i_rdata = d_rdata = 0.
  - last_grant = 1 (so I wins first in round-robin mode).
  - Starve counter = 0.
  - No grant is issued in a cycle with Reset high.

## Timing
- Accept at edge N -> rsp_valid high and rdata stable during cycle N+1, low at N+2 unless another accept occurred.
- Ready has zero-cycle latency from valid, with a combinational path valid -> ready and valid -> mem_*.
- Throughput: 1 access per cycle total, shared between both ports.
- Starvation bound (fixed mode): with d_valid held high, I is granted no later than STARVE_LIMIT+1 cycles after i_valid rises.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - When both ports are valid, the port not equal to last_grant wins.
  - last_grant updates on every accept.
  - The starve counter is not implemented, and STARVE_LIMIT is ignored.
- DMEM_ARB_RR_EN undefined: fixed priority D > I with the starvation override described above.

## Test plan
- Reset then idle: all outputs are 0 for 3 cycles, including mem_we = 0.
- D writes addr 32'h10, be 4'b0011, wdata 32'hAABBCCDD over an old word of 32'h11223344; next cycle D reads 32'h10 -> d_rdata = 32'h1122CCDD with d_rsp_valid high for exactly one cycle.
- Fixed mode, STARVE_LIMIT = 4, both ports valid continuously:
  - D is granted for 4 cycles, then I is granted in the 5th cycle.
  - The pattern repeats.
- RR mode, both ports valid: after reset, grants alternate I, D, I, D. i_rsp_valid and d_rsp_valid are never high in the same cycle.
- Reset asserted in the cycle after a D read accept: d_rsp_valid = 0 the following cycle, and no grant occurs while Reset is high.
- I read of 32'h0 and D write in the same cycle (fixed mode, counter 0): d_ready = 1, i_ready = 0. I is accepted next cycle and returns the pre-existing word at 32'h0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports (I = instruction fetch, D = load/store)
// and the data-memory side of dmem_arbiter. The arbiter is the slave; the
// pipeline and memory array together form the master view.
interface dmem_arbiter_if;
  // Port I
  logic        i_valid;
  logic [31:0] i_addr;
  logic [3:0]  i_be;
  logic [31:0] i_wdata;
  logic        i_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rdata;
  // Port D
  logic        d_valid;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;
  // Memory side
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr, i_be, i_wdata,
    output i_ready, i_rsp_valid, i_rdata,
    input  d_valid, d_addr, d_be, d_wdata,
    output d_ready, d_rsp_valid, d_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_valid, i_addr, i_be, i_wdata,
    input  i_ready, i_rsp_valid, i_rdata,
    output d_valid, d_addr, d_be, d_wdata,
    input  d_ready, d_rsp_valid, d_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported, byte-enabled data memory.
// Grants at most one of I / D per cycle, steers its address, write data and
// byte enables to memory, and returns registered read data one cycle later.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority D > I with a starvation override for I after STARVE_LIMIT
// waiting cycles.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4  // 1..255, fixed-priority mode only
) (
  input logic           Clk,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);

  logic        grantI;
  logic        grantD;
  logic        iRspValid;
  logic        dRspValid;
  logic [31:0] iRdata;
  logic [31:0] dRdata;

`ifdef DMEM_ARB_RR_EN
  logic lastGrant;  // 0 = I, 1 = D

  // Round-robin grant: on contention the port that did not win last time wins.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (!Reset) begin
      if (bus.i_valid && bus.d_valid) begin
        grantI = lastGrant;
        grantD = !lastGrant;
      end else begin
        grantI = bus.i_valid;
        grantD = bus.d_valid;
      end
    end
  end

  // Remember the winner of every accepted request.
  // NOTE: clocked state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lastGrant <= 1'b1;  // I wins the first contention after reset
    end else if (grantI || grantD) begin
      lastGrant <= grantD;
    end
  end
`else
  localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);
  logic [7:0] starveCnt;

  // Fixed priority D > I, unless I has waited StarveLim cycles.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (!Reset) begin
      if (bus.i_valid && (!bus.d_valid || starveCnt >= StarveLim)) begin
        grantI = 1'b1;
      end else begin
        grantD = bus.d_valid;
      end
    end
  end

  // Count consecutive cycles I waits while requesting; saturates at 255.
  // NOTE: clocked state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (Reset || !bus.i_valid || grantI) begin
      starveCnt <= 8'd0;
    end else if (starveCnt != 8'hFF) begin
      starveCnt <= starveCnt + 8'd1;
    end
  end
`endif

  assign bus.i_ready = grantI;
  assign bus.d_ready = grantD;

  // Steer the granted port onto the memory bus; drive zeros when idle.
  always_comb begin
    bus.mem_addr  = 32'h0;
    bus.mem_we    = 4'h0;
    bus.mem_wdata = 32'h0;
    if (grantD) begin
      bus.mem_addr  = {bus.d_addr[31:2], 2'b00};
      bus.mem_we    = bus.d_be;
      bus.mem_wdata = bus.d_wdata;
    end else if (grantI) begin
      bus.mem_addr  = {bus.i_addr[31:2], 2'b00};
      bus.mem_we    = bus.i_be;
      bus.mem_wdata = bus.i_wdata;
    end
  end

  // One-cycle response: read data for reads, zero for writes; reset drops it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      iRspValid <= 1'b0;
      dRspValid <= 1'b0;
      iRdata    <= 32'h0;
      dRdata    <= 32'h0;
    end else begin
      iRspValid <= grantI;
      dRspValid <= grantD;
      if (grantI) iRdata <= (bus.i_be == 4'h0) ? bus.mem_rdata : 32'h0;
      if (grantD) dRdata <= (bus.d_be == 4'h0) ? bus.mem_rdata : 32'h0;
    end
  end

  assign bus.i_rsp_valid = iRspValid;
  assign bus.d_rsp_valid = dRspValid;
  assign bus.i_rdata     = iRdata;
  assign bus.d_rdata     = dRdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled memory model
// (combinational read, write on the rising edge). Covers the default
// fixed-priority build, or the round-robin build when DMEM_ARB_RR_EN is set.
module tb_dmem_arbiter;

  logic Clk = 1'b0;
  logic Reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Memory model: 16 words, preloaded on reset.
  logic [31:0] memArr [0:15];
  assign bus.mem_rdata = memArr[bus.mem_addr[5:2]];

  always @(posedge Clk) begin
    if (Reset) begin
      for (int w = 0; w < 16; w++) memArr[w] <= 32'h0;
      memArr[0] <= 32'hCAFE0000;
      memArr[4] <= 32'h11223344;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) memArr[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic driveI(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus.i_valid = v; bus.i_addr = a; bus.i_be = be; bus.i_wdata = wd;
  endtask

  task automatic driveD(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus.d_valid = v; bus.d_addr = a; bus.d_be = be; bus.d_wdata = wd;
  endtask

  // Advance to the next falling edge; inputs are driven and outputs sampled there.
  task automatic nextCycle();
    @(negedge Clk);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_ctl"}, {28'h0, bus.i_ready, bus.d_ready, bus.i_rsp_valid, bus.d_rsp_valid}, 32'h0);
    check({tag, "_maddr"}, bus.mem_addr, 32'h0);
    check({tag, "_mwe"}, {28'h0, bus.mem_we}, 32'h0);
    check({tag, "_mwdata"}, bus.mem_wdata, 32'h0);
    check({tag, "_irdata"}, bus.i_rdata, 32'h0);
    check({tag, "_drdata"}, bus.d_rdata, 32'h0);
  endtask

  task automatic applyReset();
    nextCycle();
    Reset = 1'b1;
    driveI(1'b0, 32'h0, 4'h0, 32'h0);
    driveD(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    check("rst_no_dready", {31'h0, bus.d_ready}, 32'h0);
    check("rst_no_mwe", {28'h0, bus.mem_we}, 32'h0);
    nextCycle();
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    driveI(1'b0, 32'h0, 4'h0, 32'h0);
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
    applyReset();

    // Reset then idle for 3 cycles: everything zero.
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      #1;
      checkIdle("idle");
    end

    // D partial write to 0x10 (low address bits ignored), then read back.
    nextCycle();
    driveD(1'b1, 32'h13, 4'b0011, 32'hAABBCCDD);
    #1;
    check("wr_dready", {31'h0, bus.d_ready}, 32'h1);
    check("wr_iready", {31'h0, bus.i_ready}, 32'h0);
    check("wr_maddr", bus.mem_addr, 32'h10);
    check("wr_mwe", {28'h0, bus.mem_we}, 32'h3);
    check("wr_mwdata", bus.mem_wdata, 32'hAABBCCDD);
    nextCycle();
    driveD(1'b1, 32'h10, 4'h0, 32'h0);
    #1;
    check("wr_rsp", {31'h0, bus.d_rsp_valid}, 32'h1);
    check("wr_rdata", bus.d_rdata, 32'h0);
    check("rd_mwe", {28'h0, bus.mem_we}, 32'h0);
    nextCycle();
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("rd_rsp", {31'h0, bus.d_rsp_valid}, 32'h1);
    check("rd_irsp", {31'h0, bus.i_rsp_valid}, 32'h0);
    check("rd_rdata", bus.d_rdata, 32'h1122CCDD);
    nextCycle();
    #1;
    check("rd_rsp_once", {31'h0, bus.d_rsp_valid}, 32'h0);

`ifdef DMEM_ARB_RR_EN
    // Round-robin: after reset, contention alternates I, D, I, D.
    applyReset();
    nextCycle();
    driveI(1'b1, 32'h0, 4'h0, 32'h0);
    driveD(1'b1, 32'h10, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_iready_%0d", k), {31'h0, bus.i_ready}, {31'h0, (k % 2 == 0)});
      check($sformatf("rr_dready_%0d", k), {31'h0, bus.d_ready}, {31'h0, (k % 2 == 1)});
      check($sformatf("rr_rsp_excl_%0d", k), {31'h0, bus.i_rsp_valid & bus.d_rsp_valid}, 32'h0);
      nextCycle();
    end
    driveI(1'b0, 32'h0, 4'h0, 32'h0);
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
`else
    // Simultaneous I read of 0x0 and D write: D first, then I reads old word.
    nextCycle();
    driveI(1'b1, 32'h0, 4'h0, 32'h0);
    driveD(1'b1, 32'h20, 4'hF, 32'h12345678);
    #1;
    check("mix_dready", {31'h0, bus.d_ready}, 32'h1);
    check("mix_iready", {31'h0, bus.i_ready}, 32'h0);
    nextCycle();
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("mix_iready2", {31'h0, bus.i_ready}, 32'h1);
    check("mix_maddr", bus.mem_addr, 32'h0);
    check("mix_drsp", {31'h0, bus.d_rsp_valid}, 32'h1);
    nextCycle();
    driveI(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("mix_irsp", {31'h0, bus.i_rsp_valid}, 32'h1);
    check("mix_irdata", bus.i_rdata, 32'hCAFE0000);
    check("mix_drsp_off", {31'h0, bus.d_rsp_valid}, 32'h0);

    // Starvation: both valid continuously -> D,D,D,D,I repeating.
    nextCycle();
    driveI(1'b1, 32'h0, 4'h0, 32'h0);
    driveD(1'b1, 32'h10, 4'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("stv_iready_%0d", k), {31'h0, bus.i_ready}, {31'h0, (k % 5 == 4)});
      check($sformatf("stv_dready_%0d", k), {31'h0, bus.d_ready}, {31'h0, (k % 5 != 4)});
      check($sformatf("stv_rsp_excl_%0d", k), {31'h0, bus.i_rsp_valid & bus.d_rsp_valid}, 32'h0);
      nextCycle();
    end
    driveI(1'b0, 32'h0, 4'h0, 32'h0);
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
`endif

    // Reset in the cycle after a D read accept drops the response.
    nextCycle();
    driveD(1'b1, 32'h10, 4'h0, 32'h0);
    #1;
    check("rr_pre_dready", {31'h0, bus.d_ready}, 32'h1);
    nextCycle();
    Reset = 1'b1;
    #1;
    check("rst_mid_dready", {31'h0, bus.d_ready}, 32'h0);
    check("rst_mid_mwe_addr", bus.mem_addr, 32'h0);
    nextCycle();
    #1;
    check("rst_mid_drsp", {31'h0, bus.d_rsp_valid}, 32'h0);
    check("rst_mid_drdata", bus.d_rdata, 32'h0);
    check("rst_mid_dready2", {31'h0, bus.d_ready}, 32'h0);
    nextCycle();
    Reset = 1'b0;
    driveD(1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();
    #1;
    checkIdle("post_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
